// File: rtl/pulse_stretcher_pkg.sv
// Shared state encoding and sizing helper for the pulse stretcher.
// Used by pulse_stretcher and its load_down_counter instance.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // Wide enough to hold the larger of the two reload values.
  function automatic int cnt_width(input int stretch, input int holdoff);
    int largest;
    largest = (stretch > holdoff) ? stretch : holdoff;
    return (largest < 1) ? 1 : $clog2(largest + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger strobe in, stretched level and status strobes out.
// The master side drives pulse; the slave side (the stretcher) drives the rest.
interface pulse_stretcher_if;
  logic pulse;
  logic level;
  logic busy;
  logic dropped;

  modport master (output pulse, input level, input busy, input dropped);
  modport slave  (input pulse, output level, output busy, output dropped);
endinterface

// File: rtl/pulse_stretcher_load_down_counter.sv
// Loadable down-counter; load wins over enable, zero flags an exhausted count.
// The owner only enables it while the count is non-zero, so it never wraps.
module load_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-clock strobes into a STRETCH_CYCLES-wide level plus a hold-off window.
// Define PULSE_STRETCHER_RETRIGGER_EN to let pulses during the level restart its width.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int STRETCH_CYCLES = 10,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  pulse_stretcher_if.slave  bus
);

  localparam int CNT_W = cnt_width(STRETCH_CYCLES, HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD =
      (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  state_t           state_reg, state_next;
  logic             level_reg, busy_reg, dropped_reg;
  logic             ignored;
  logic             cnt_load, cnt_en, cnt_zero, cnt_done;
  logic [CNT_W-1:0] cnt_load_value, cnt_count;

  load_down_counter #(.CNT_W(CNT_W)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .enable     (cnt_en),
    .count      (cnt_count),
    .zero       (cnt_zero)
  );

  assign cnt_en   = (state_reg != ST_IDLE) && !cnt_zero;
  assign cnt_done = (cnt_count == '0);

  always_comb begin
    state_next     = state_reg;
    cnt_load       = 1'b0;
    cnt_load_value = STRETCH_LOAD;
    ignored        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.pulse) begin
          state_next = ST_ACTIVE;
          cnt_load   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (RETRIGGER && bus.pulse) begin
          cnt_load = 1'b1;
        end else begin
          ignored = bus.pulse;
          if (cnt_done) begin
            if (HOLDOFF_CYCLES == 0) begin
              state_next = ST_IDLE;
            end else begin
              state_next     = ST_HOLDOFF;
              cnt_load       = 1'b1;
              cnt_load_value = HOLDOFF_LOAD;
            end
          end
        end
      end
      ST_HOLDOFF: begin
        // Includes the edge that returns to IDLE: that sample is still ignored.
        ignored = bus.pulse;
        if (cnt_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      level_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      dropped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      level_reg   <= (state_next == ST_ACTIVE);
      busy_reg    <= (state_next != ST_IDLE);
      dropped_reg <= ignored;
    end
  end

  assign bus.level   = level_reg;
  assign bus.busy    = busy_reg;
  assign bus.dropped = dropped_reg;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed scenarios for pulse_stretcher; expected {level,busy,dropped} per cycle go
// into a queue and a negedge monitor pops and compares them.
module tb_pulse_stretcher;

  typedef struct {
    int         scn;
    int         k;
    logic [2:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  exp_t exp_q[$];

  pulse_stretcher_if bus ();

  pulse_stretcher #(
    .STRETCH_CYCLES (10),
    .HOLDOFF_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_rng(input int k, input int a, input int b);
    return (k >= a) && (k <= b);
  endfunction

  function automatic logic pulse_at(input int scn, input int k);
    case (scn)
      2: return k == 20;
      3: return (k == 20) || (k == 25);
      4: return (k == 20) || (k == 31) || (k == 32) || (k == 33);
      5: return in_rng(k, 20, 59);
      6: return (k == 20) || (k == 30);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rst_at(input int scn, input int k);
    return (k < 4) || ((scn == 6) && ((k == 25) || (k == 26)));
  endfunction

  // Hand-derived windows, cycle k = interval after the k-th rising edge of the scenario.
  function automatic logic [2:0] expect_at(input int scn, input int k);
    logic l, b, d;
    l = 1'b0; b = 1'b0; d = 1'b0;
    case (scn)
      2: begin
        l = in_rng(k, 21, 30);
        b = in_rng(k, 21, 32);
      end
      3: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        l = in_rng(k, 21, 35);
        b = in_rng(k, 21, 37);
`else
        l = in_rng(k, 21, 30);
        b = in_rng(k, 21, 32);
        d = (k == 26);
`endif
      end
      4: begin
        l = in_rng(k, 21, 30) || in_rng(k, 34, 43);
        b = in_rng(k, 21, 32) || in_rng(k, 34, 45);
        d = (k == 32) || (k == 33);
      end
      5: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        l = in_rng(k, 21, 69);
        b = in_rng(k, 21, 71);
`else
        l = in_rng(k, 21, 30) || in_rng(k, 34, 43) || in_rng(k, 47, 56) || in_rng(k, 60, 69);
        b = in_rng(k, 21, 32) || in_rng(k, 34, 45) || in_rng(k, 47, 58) || in_rng(k, 60, 71);
        d = in_rng(k, 22, 33) || in_rng(k, 35, 46) || in_rng(k, 48, 59);
`endif
      end
      6: begin
        l = in_rng(k, 21, 24) || in_rng(k, 31, 40);
        b = in_rng(k, 21, 24) || in_rng(k, 31, 42);
      end
      default: ;
    endcase
    return {l, b, d};
  endfunction

  task automatic run_scn(input int scn, input int len);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      @(posedge clk);
      #1;
      bus.pulse = pulse_at(scn, k);
      e.scn = scn;
      e.k   = k;
      e.val = expect_at(scn, k);
      exp_q.push_back(e);
      // Reset changes land mid-cycle so the negedge sample shows the async clear.
      #1;
      rst = rst_at(scn, k);
    end
    $display("scenario %0d: %0d cycles issued", scn, len);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [2:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.level, bus.busy, bus.dropped};
        compared++;
        if (act !== e.val) begin
          mismatched++;
          $display("FAIL scn%0d cycle %0d {level,busy,dropped}: got %b want %b",
                   e.scn, e.k, act, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    bus.pulse  = 1'b0;
    run_scn(2, 36);
    run_scn(3, 40);
    run_scn(4, 48);
    run_scn(5, 75);
    run_scn(6, 45);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
